// File: rtl/rom_pkg.sv
// Shared constants for the instruction-ROM read port: geometry, fill word,
// word-index slice and requester IDs.
package rom_pkg;

  localparam int          ROM_WORDS = 32;
  localparam logic [31:0] FILL_WORD = 32'h8000_0000;
  localparam int          IDX_HI    = 9;
  localparam int          IDX_LO    = 2;

  typedef enum logic {
    REQ_IF   = 1'b0,
    REQ_DATA = 1'b1
  } req_id_e;

  // A read is illegal when it is not word aligned or falls past the last ROM word.
  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[IDX_LO-1:0] != '0) || (addr[31:IDX_LO] >= 30'(ROM_WORDS));
  endfunction

endpackage

// File: rtl/rom_resp_reg.sv
// Per-requester response register: one-cycle rvalid pulse plus held read data.
// With ROM_PORT_ARBITER_ADDR_CHECK_EN defined it also flags illegal addresses.
module rom_resp_reg
  import rom_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        gnt,
`ifdef ROM_PORT_ARBITER_ADDR_CHECK_EN
  input  logic [31:0] addr,
  output logic        err,
`endif
  input  logic [31:0] rom_data,
  output logic        rvalid,
  output logic [31:0] rdata
);

  logic [31:0] word;

`ifdef ROM_PORT_ARBITER_ADDR_CHECK_EN
  logic bad;
  assign bad  = addr_bad(addr);
  assign word = bad ? FILL_WORD : rom_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else        err <= gnt & bad;
  end
`else
  assign word = rom_data;
`endif

  // Data is only captured on a grant so the last response stays readable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= gnt;
      if (gnt) rdata <= word;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the combinational instruction ROM between IF (fixed priority) and a
// data/debug port with anti-starvation. Optional: ROM_PORT_ARBITER_ADDR_CHECK_EN.
module rom_port_arbiter
  import rom_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] addr0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic [31:0] addr1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
`ifdef ROM_PORT_ARBITER_ADDR_CHECK_EN
  output logic        err0,
  output logic        err1,
`endif
  output logic        stall_if,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  req_id_e    sel;

  // Requester 1 wins when alone or once it has been blocked WAIT_LIMIT times.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    sel  = REQ_IF;
    if (reset) begin
      if (req1 && (!req0 || wait_cnt == WAIT_LIMIT)) begin
        gnt1 = 1'b1;
        sel  = REQ_DATA;
      end else if (req0) begin
        gnt0 = 1'b1;
      end
    end
  end

  assign rom_addr = !reset ? '0 : ((sel == REQ_DATA) ? addr1 : addr0);
  assign stall_if = reset & req0 & ~gnt0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               wait_cnt <= '0;
    else if (gnt1 || !req1)                   wait_cnt <= '0;
    else if (gnt0 && wait_cnt != WAIT_LIMIT)  wait_cnt <= wait_cnt + 4'd1;
  end

  rom_resp_reg u_resp0 (
    .clk      (clk),
    .reset    (reset),
    .gnt      (gnt0),
`ifdef ROM_PORT_ARBITER_ADDR_CHECK_EN
    .addr     (addr0),
    .err      (err0),
`endif
    .rom_data (rom_data),
    .rvalid   (rvalid0),
    .rdata    (rdata0)
  );

  rom_resp_reg u_resp1 (
    .clk      (clk),
    .reset    (reset),
    .gnt      (gnt1),
`ifdef ROM_PORT_ARBITER_ADDR_CHECK_EN
    .addr     (addr1),
    .err      (err1),
`endif
    .rom_data (rom_data),
    .rvalid   (rvalid1),
    .rdata    (rdata1)
  );

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single combinational instruction-ROM read port between two requesters.
- Requester 0 is the pipeline IF stage. Requester 1 is the data/debug side, e.g. lw from text space or a test-bench memory dump.
- Arbitrates every cycle, drives the ROM address and registers the ROM word, so responses arrive with fixed 1-cycle latency.
- Fixed priority to IF, with an anti-starvation counter that guarantees requester 1 progress.

Parameters:
- ROM_WORDS, 32, number of valid ROM words; word index is addr[9:2].
- MAX_WAIT, 4, consecutive cycles requester 1 may be blocked by IF before it is forced ahead (1..15).
- FILL_WORD, 32'h80000000, word returned on suppressed or invalid reads.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low; all state clears on negedge reset.
- req0  in  1  IF read request.
- addr0  in  32  IF byte address.
- gnt0  out  1  combinational grant to IF this cycle.
- rvalid0  out  1  IF response valid, one cycle after gnt0.
- rdata0  out  32  IF read data.
- req1  in  1  data/debug read request.
- addr1  in  32  data/debug byte address.
- gnt1  out  1  combinational grant to requester 1.
- rvalid1  out  1  requester 1 response valid.
- rdata1  out  32  requester 1 read data.
- stall_if  out  1  high when req0 is asserted and gnt0 is low; feeds the pipeline hazard unit.
- rom_addr  out  32  address to the ROM port.
- rom_data  in  32  combinational ROM output.

Behaviour:
- Reset values: gnt0/gnt1 = 0, rvalid0/rvalid1 = 0, rdata0/rdata1 = 0, stall_if = 0, wait_cnt = 0, rom_addr = 0.
- Requesters hold req and addr stable until granted. Each grant produces exactly one response.
- Grant logic (combinational):
  - only req0 → gnt0;
  - only req1 → gnt1;
  - both and wait_cnt < MAX_WAIT → gnt0;
  - both and wait_cnt == MAX_WAIT → gnt1;
  - neither → no grant, rom_addr = addr0.
- rom_addr = addr of the granted requester.
- wait_cnt, on posedge:
  - cleared when gnt1 or !req1;
  - incremented when req1 && gnt0;
  - saturates at MAX_WAIT.
- Response register, on posedge:
  - rvalidN <= gntN;
  - rdataN <= rom_data when gntN, otherwise holds its previous value.
- Latency: grant in cycle T → rvalid and rdata valid in cycle T+1, for exactly one cycle.
- Back-to-back grants to the same requester are allowed on every cycle, giving full throughput.
- stall_if = req0 & ~gnt0. It is asserted only in the forced-grant cycle.
- Simultaneous events:
  - When requester 1's forced grant coincides with req0, IF stalls exactly one cycle.
  - wait_cnt clears in the same edge as that grant.
- Reset mid-operation: an in-flight response is dropped (rvalid forced 0). Requesters must reissue after reset deasserts.
- Word-aligned access only: addr[1:0] is ignored unless ADDR_CHECK_EN is defined.

Optional Feature:
- Macro: ROM_PORT_ARBITER_ADDR_CHECK_EN.
- When defined:
  - Adds outputs err0 and err1 (1 bit each, reset 0), asserted together with rvalidN.
  - errN is set when the granted address is misaligned (addr[1:0] != 0) or addr[31:2] >= ROM_WORDS.
  - On error, rdataN = FILL_WORD and rom_data is ignored.
- When undefined: no err ports; data is always rom_data.

Decomposition:
- Shared package (rom_pkg) holds:
  - ROM_WORDS;
  - FILL_WORD (the illegal/nop-trap word 32'h80000000);
  - the word-index slice constant (bits 9:2);
  - the requester ID encoding (REQ_IF = 0, REQ_DATA = 1).
- One natural sub-module: rom_resp_reg. It is the per-requester rvalid/rdata (and err) register, instantiated twice.
- Arbitration and wait_cnt stay inline.

Test Plan:
- IF-only stream: req0 = 1 with addr0 = 0,4,8,…,44, req1 = 0 → gnt0 every cycle; rvalid0 follows one cycle later with rdata0 = ROM words 0..11 in order; stall_if = 0 throughout.
- Contention with MAX_WAIT = 4: req0 and req1 held high, addr1 = 0x18 → gnt0 for 4 cycles, then gnt1 and stall_if = 1 for one cycle. Next cycle rvalid1 = 1 with rdata1 = ROM word 6 (add $t0); wait_cnt returns to 0.
- Data-only: req1 = 1, addr1 = 0x2C, req0 = 0 → gnt1 immediately; next cycle rdata1 = 32'h0800000B (j 11).
- Out-of-range read: addr0 = 0x200 → rdata0 = 32'h80000000. With ROM_PORT_ARBITER_ADDR_CHECK_EN defined, err0 = 1 in the rvalid0 cycle; addr0 = 0x6 also gives err0 = 1.
- Reset mid-operation: assert reset low asynchronously between the grant edge and the response → rvalid0/1, rdata0/1 and wait_cnt read 0 immediately; after release, the first grant behaves as from reset.
